// File: rtl/succ_mult_pkg.sv
// -----------------------------------------------------------------------------
// succ_mult_pkg
// Shared types for the successive-addition multiplier.
//   state_t    : controller states (IDLE, LOAD_B, CHECK, ADD, DONE)
//   prod_width : product width for a given operand width (2*width)
// -----------------------------------------------------------------------------
package succ_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    CHECK,
    ADD,
    DONE
  } state_t;

  // The full product of two width-bit unsigned numbers always fits in
  // 2*width bits, so the accumulator can never overflow.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/succ_mult_dp.sv
// -----------------------------------------------------------------------------
// succ_mult_dp
// Datapath of the successive-addition multiplier.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   ld_a, ld_b : capture din into the A / B operand registers
//   init       : pick count/addend from A and B, clear the accumulator
//   add_en     : acc += addend, count -= 1
//   ld_prod    : update the product register (with sum when adding, else 0)
//   din        : shared operand bus
//   any_zero   : A or B is zero
//   count_one  : this is the last addition
//   product    : held result
// -----------------------------------------------------------------------------
module succ_mult_dp
  import succ_mult_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_a,
  input  logic                         ld_b,
  input  logic                         init,
  input  logic                         add_en,
  input  logic                         ld_prod,
  input  logic [WIDTH-1:0]             din,
  output logic                         any_zero,
  output logic                         count_one,
  output logic [prod_width(WIDTH)-1:0] product
);

  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] addend_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    sum;
  logic             use_swap;

  // Swap only when A is strictly smaller; a tie keeps count=B, addend=A.
  assign use_swap  = SWAP_EN && (a_q < b_q);
  assign any_zero  = (a_q == '0) || (b_q == '0);
  assign count_one = (count_q == WIDTH'(1));
  assign sum       = acc_q + PW'(addend_q);
  assign product   = prod_q;

  // The product register is written on the same edge that enters DONE, so the
  // new result is visible together with the done pulse and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      count_q  <= '0;
      addend_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
    end else begin
      if (ld_a) begin
        a_q <= din;
      end
      if (ld_b) begin
        b_q <= din;
      end
      if (init) begin
        count_q  <= use_swap ? a_q : b_q;
        addend_q <= use_swap ? b_q : a_q;
        acc_q    <= '0;
      end
      if (add_en) begin
        acc_q   <= sum;
        count_q <= count_q - WIDTH'(1);
      end
      if (ld_prod) begin
        prod_q <= add_en ? sum : '0;
      end
    end
  end

endmodule

// File: rtl/succ_add_mult_param.sv
// -----------------------------------------------------------------------------
// succ_add_mult_param
// Multiply-by-successive-addition engine: controller FSM plus datapath.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : request, sampled only in IDLE
//   din     : A in the start cycle, B in the following cycle
//   busy    : high in every state except IDLE
//   done    : one-cycle pulse, product valid from this cycle
//   product : result, held until replaced by the next result or reset
// -----------------------------------------------------------------------------
module succ_add_mult_param
  import succ_mult_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             din,
  output logic                         busy,
  output logic                         done,
  output logic [prod_width(WIDTH)-1:0] product
);

  state_t state_q;
  state_t state_d;

  logic ld_a;
  logic ld_b;
  logic init;
  logic add_en;
  logic ld_prod;
  logic any_zero;
  logic count_one;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control. A zero operand skips ADD entirely and
  // goes straight to DONE with a zero product.
  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    init    = 1'b0;
    add_en  = 1'b0;
    ld_prod = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld_a    = 1'b1;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        ld_b    = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        init = 1'b1;
        if (any_zero) begin
          ld_prod = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        add_en = 1'b1;
        if (count_one) begin
          ld_prod = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  succ_mult_dp #(
    .WIDTH  (WIDTH),
    .SWAP_EN(SWAP_EN)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .init     (init),
    .add_en   (add_en),
    .ld_prod  (ld_prod),
    .din      (din),
    .any_zero (any_zero),
    .count_one(count_one),
    .product  (product)
  );

endmodule
